// File: rtl/mem_addr_seq.sv
// mem_addr_seq: registered memory-address sequencer for the multicycle MIPS core.
// Chooses PC / exception vector / RD address / ALUOut on an accepted request,
// holds the address stable until the memory completes or the access times out,
// and keeps sticky pending-exception bits with bit 0 as the highest priority.
module mem_addr_seq #(
    parameter int ADDR_W   = 32,
    parameter int NUM_VEC  = 3,
    parameter int VEC_BASE = 253,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        sel,
    input  logic [ADDR_W-1:0] pc_src,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic              req,
    input  logic              mem_ready,
    input  logic [NUM_VEC-1:0] exc_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_valid,
    output logic              busy,
    output logic              done,
    output logic [NUM_VEC-1:0] exc_pending,
    output logic [3:0]        exc_cause,
    output logic              err,
    output logic [1:0]        err_code
);

    // Source select encoding
    localparam logic [1:0] SEL_PC  = 2'b00;
    localparam logic [1:0] SEL_VEC = 2'b01;
    localparam logic [1:0] SEL_RD  = 2'b10;
    localparam logic [1:0] SEL_ALU = 2'b11;

    // Error codes
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NO_VEC  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // The counter holds completed WAIT cycles; the cycle in which it equals
    // CNT_LAST is the TIMEOUT-th WAIT cycle, and mem_ready there still wins.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_valid_q, mem_valid_d;
    logic                done_q, done_d;
    logic [NUM_VEC-1:0]  exc_pending_q, exc_pending_d;
    logic [3:0]          exc_cause_q, exc_cause_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                vec_acc_q, vec_acc_d;
    logic [3:0]          vec_idx_q, vec_idx_d;

    logic [NUM_VEC-1:0]  pend_clr;
    logic [3:0]          pick_idx;

    // Index of the lowest set bit (highest-priority pending exception).
    function automatic logic [3:0] lowest_set(input logic [NUM_VEC-1:0] bits);
        logic [3:0] idx;
        logic       found;
        idx   = 4'd0;
        found = 1'b0;
        for (int i = 0; i < NUM_VEC; i++) begin
            if (!found && bits[i]) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Vector address: base plus index, silently truncated to ADDR_W bits.
    function automatic logic [ADDR_W-1:0] vec_addr(input logic [3:0] idx);
        return ADDR_W'(VEC_BASE) + ADDR_W'(idx);
    endfunction

    // One-hot clear mask for the pending bit served by a vector access.
    function automatic logic [NUM_VEC-1:0] idx_mask(input logic [3:0] idx);
        logic [NUM_VEC-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_VEC; i++) begin
            m[i] = (idx == 4'(i));
        end
        return m;
    endfunction

    assign pick_idx = lowest_set(exc_pending_q);

    // State register and all datapath/status flops, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            mem_addr_q    <= '0;
            mem_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            exc_pending_q <= '0;
            exc_cause_q   <= '0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
            vec_acc_q     <= 1'b0;
            vec_idx_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_addr_q    <= mem_addr_d;
            mem_valid_q   <= mem_valid_d;
            done_q        <= done_d;
            exc_pending_q <= exc_pending_d;
            exc_cause_q   <= exc_cause_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            vec_acc_q     <= vec_acc_d;
            vec_idx_q     <= vec_idx_d;
        end
    end

    // Next-state, address capture, completion/timeout and pending-bit update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_valid_d = mem_valid_q;
        done_d      = 1'b0;
        exc_cause_d = exc_cause_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        vec_acc_d   = vec_acc_q;
        vec_idx_d   = vec_idx_q;
        pend_clr    = '0;

        case (state_q)
            ST_IDLE: begin
                mem_valid_d = 1'b0;
                cnt_d       = '0;
                if (req) begin
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    case (sel)
                        SEL_PC: begin
                            mem_addr_d  = pc_src;
                            mem_valid_d = 1'b1;
                            vec_acc_d   = 1'b0;
                            state_d     = ST_WAIT;
                        end
                        SEL_RD: begin
                            mem_addr_d  = rd_addr;
                            mem_valid_d = 1'b1;
                            vec_acc_d   = 1'b0;
                            state_d     = ST_WAIT;
                        end
                        SEL_ALU: begin
                            mem_addr_d  = alu_out;
                            mem_valid_d = 1'b1;
                            vec_acc_d   = 1'b0;
                            state_d     = ST_WAIT;
                        end
                        SEL_VEC: begin
                            if (exc_pending_q != '0) begin
                                mem_addr_d  = vec_addr(pick_idx);
                                exc_cause_d = pick_idx;
                                vec_idx_d   = pick_idx;
                                vec_acc_d   = 1'b1;
                                mem_valid_d = 1'b1;
                                state_d     = ST_WAIT;
                            end else begin
                                // Nothing to vector to: report and stay idle,
                                // leaving the previous address on the bus.
                                err_d      = 1'b1;
                                err_code_d = ERR_NO_VEC;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end

            ST_WAIT: begin
                if (mem_ready) begin
                    done_d      = 1'b1;
                    mem_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                    if (vec_acc_q) begin
                        pend_clr = idx_mask(vec_idx_q);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_valid_d = 1'b0;
                    cnt_d       = '0;
                    err_d       = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                mem_valid_d = 1'b0;
                cnt_d       = '0;
            end
        endcase

        // A new request on the same edge as the clear keeps the bit set.
        exc_pending_d = (exc_pending_q & ~pend_clr) | exc_req;
    end

    assign mem_addr    = mem_addr_q;
    assign mem_valid   = mem_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign exc_pending = exc_pending_q;
    assign exc_cause   = exc_cause_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_mem_addr_seq.sv
// Testbench for mem_addr_seq: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_addr_seq;

    localparam int ADDR_W   = 32;
    localparam int NUM_VEC  = 3;
    localparam int VEC_BASE = 253;
    localparam int TIMEOUT  = 15;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         sel;
    logic [ADDR_W-1:0]  pc_src, rd_addr, alu_out;
    logic               req, mem_ready;
    logic [NUM_VEC-1:0] exc_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_valid, busy, done;
    logic [NUM_VEC-1:0] exc_pending;
    logic [3:0]         exc_cause;
    logic               err;
    logic [1:0]         err_code;

    int checks   = 0;
    int failures = 0;

    // Reference model state (what the outputs should read after the last edge)
    logic [ADDR_W-1:0]  m_addr;
    logic               m_valid, m_done, m_err, m_in_access, m_vec_acc;
    logic [NUM_VEC-1:0] m_pend;
    logic [3:0]         m_cause;
    logic [1:0]         m_code;
    int                 m_elapsed, m_vec_idx;

    mem_addr_seq #(
        .ADDR_W(ADDR_W), .NUM_VEC(NUM_VEC), .VEC_BASE(VEC_BASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .pc_src(pc_src), .rd_addr(rd_addr),
        .alu_out(alu_out), .req(req), .mem_ready(mem_ready), .exc_req(exc_req),
        .mem_addr(mem_addr), .mem_valid(mem_valid), .busy(busy), .done(done),
        .exc_pending(exc_pending), .exc_cause(exc_cause), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = '0; m_valid = 0; m_done = 0; m_err = 0; m_code = 0;
        m_pend = '0; m_cause = 0; m_in_access = 0; m_vec_acc = 0;
        m_elapsed = 0; m_vec_idx = 0;
    endtask

    // One clock edge of the access protocol, using the currently driven inputs.
    task automatic model_step();
        logic [NUM_VEC-1:0] pend_next;
        int i;
        pend_next = m_pend;
        m_done = 0;
        if (!m_in_access) begin
            if (req) begin
                m_err = 0; m_code = 2'b00;
                if (sel == 2'b01) begin
                    if (m_pend == 0) begin
                        m_err = 1; m_code = 2'b01;
                    end else begin
                        i = 0;
                        while (!m_pend[i]) i++;
                        m_addr = 32'(VEC_BASE + i);
                        m_cause = 4'(i);
                        m_vec_idx = i; m_vec_acc = 1;
                        m_in_access = 1; m_valid = 1; m_elapsed = 0;
                    end
                end else begin
                    m_addr = (sel == 2'b00) ? pc_src : (sel == 2'b10) ? rd_addr : alu_out;
                    m_vec_acc = 0;
                    m_in_access = 1; m_valid = 1; m_elapsed = 0;
                end
            end
        end else begin
            m_elapsed++;
            if (mem_ready) begin
                m_in_access = 0; m_valid = 0; m_done = 1;
                if (m_vec_acc) pend_next[m_vec_idx] = 1'b0;
            end else if (m_elapsed == TIMEOUT) begin
                m_in_access = 0; m_valid = 0; m_err = 1; m_code = 2'b10;
            end
        end
        m_pend = pend_next | exc_req;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".mem_addr"},    64'(mem_addr),    64'(m_addr));
        chk({tag, ".mem_valid"},   64'(mem_valid),   64'(m_valid));
        chk({tag, ".busy"},        64'(busy),        64'(m_in_access));
        chk({tag, ".done"},        64'(done),        64'(m_done));
        chk({tag, ".exc_pending"}, 64'(exc_pending), 64'(m_pend));
        chk({tag, ".exc_cause"},   64'(exc_cause),   64'(m_cause));
        chk({tag, ".err"},         64'(err),         64'(m_err));
        chk({tag, ".err_code"},    64'(err_code),    64'(m_code));
    endtask

    // Advance one clock: model follows the edge, outputs checked on the falling edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (reset) model_step(); else model_reset();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 0; sel = 0; pc_src = 0; rd_addr = 0; alu_out = 0;
        req = 0; mem_ready = 0; exc_req = 0;
        model_reset();
        @(negedge clk);
        check_all("por");
        reset = 1;
        cycle("idle");

        // Reset in the middle of an access
        sel = 2'b10; rd_addr = 32'h40; req = 1;
        cycle("mid_acc");
        req = 0;
        chk("mid_addr", 64'(mem_addr), 64'h40);
        cycle("mid_w1");
        cycle("mid_w2");
        reset = 0;
        #1;
        model_reset();
        check_all("mid_async");
        cycle("mid_hold");
        chk("mid_nodone", 64'(done), 64'h0);
        reset = 1;

        // Plain ALUOut access, address frozen during WAIT
        sel = 2'b11; alu_out = 32'h1000; req = 1;
        cycle("pl_acc");
        chk("pl_addr", 64'(mem_addr), 64'h1000);
        chk("pl_valid", 64'(mem_valid), 64'h1);
        req = 0; sel = 2'b00; alu_out = 32'hdead_beef; pc_src = 32'h77;
        cycle("pl_w1");
        cycle("pl_w2");
        chk("pl_frozen", 64'(mem_addr), 64'h1000);
        mem_ready = 1;
        cycle("pl_rdy");
        chk("pl_done", 64'(done), 64'h1);
        chk("pl_vfall", 64'(mem_valid), 64'h0);
        mem_ready = 0;
        cycle("pl_after");
        chk("pl_done1", 64'(done), 64'h0);

        // Vector priority
        exc_req = 3'b110;
        cycle("vp_set");
        exc_req = 0;
        chk("vp_pend", 64'(exc_pending), 64'h6);
        sel = 2'b01; req = 1;
        cycle("vp_acc1");
        req = 0;
        chk("vp_addr1", 64'(mem_addr), 64'd254);
        chk("vp_cause1", 64'(exc_cause), 64'd1);
        mem_ready = 1;
        cycle("vp_done1");
        mem_ready = 0;
        chk("vp_pend1", 64'(exc_pending), 64'h4);
        req = 1;
        cycle("vp_acc2");
        req = 0;
        chk("vp_addr2", 64'(mem_addr), 64'd255);
        chk("vp_cause2", 64'(exc_cause), 64'd2);
        mem_ready = 1;
        cycle("vp_done2");
        mem_ready = 0;
        chk("vp_pend2", 64'(exc_pending), 64'h0);

        // Set wins over clear on the completion edge
        exc_req = 3'b001;
        cycle("col_set");
        exc_req = 0; sel = 2'b01; req = 1;
        cycle("col_acc");
        req = 0;
        chk("col_addr", 64'(mem_addr), 64'd253);
        cycle("col_w1");
        mem_ready = 1; exc_req = 3'b001;
        cycle("col_done");
        mem_ready = 0; exc_req = 0;
        chk("col_keep", 64'(exc_pending), 64'h1);
        chk("col_dn", 64'(done), 64'h1);

        // Drain bit 0, then request a vector with nothing pending
        req = 1;
        cycle("ev_drain_acc");
        req = 0; mem_ready = 1;
        cycle("ev_drain_done");
        mem_ready = 0;
        chk("ev_empty", 64'(exc_pending), 64'h0);
        req = 1;
        cycle("ev_req");
        req = 0;
        chk("ev_err", 64'(err), 64'h1);
        chk("ev_code", 64'(err_code), 64'h1);
        chk("ev_busy", 64'(busy), 64'h0);
        chk("ev_addr_hold", 64'(mem_addr), 64'd253);
        cycle("ev_idle");
        sel = 2'b00; pc_src = 32'h4; req = 1;
        cycle("ev_pc");
        req = 0;
        chk("ev_clr", 64'(err), 64'h0);
        chk("ev_addr", 64'(mem_addr), 64'h4);
        mem_ready = 1;
        cycle("ev_fin");
        mem_ready = 0;

        // Timeout, then completion on the last allowed cycle
        pc_src = 32'h100; req = 1;
        cycle("to_acc");
        req = 0;
        repeat (TIMEOUT - 1) cycle("to_wait");
        chk("to_busy", 64'(busy), 64'h1);
        cycle("to_exp");
        chk("to_code", 64'(err_code), 64'h2);
        chk("to_valid", 64'(mem_valid), 64'h0);
        chk("to_done", 64'(done), 64'h0);
        req = 1;
        cycle("to2_acc");
        req = 0;
        repeat (TIMEOUT - 1) cycle("to2_wait");
        mem_ready = 1;
        cycle("to2_rdy");
        mem_ready = 0;
        chk("to2_done", 64'(done), 64'h1);
        chk("to2_err", 64'(err), 64'h0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            req       = ($urandom_range(0, 2) == 0);
            sel       = 2'($urandom_range(0, 3));
            pc_src    = $urandom;
            rd_addr   = $urandom;
            alu_out   = $urandom;
            mem_ready = ($urandom_range(0, 3) == 0);
            exc_req   = ($urandom_range(0, 5) == 0) ? NUM_VEC'($urandom) : '0;
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_addr_seq.md
Name: mem_addr_seq

Overview:
- Registered, handshaked successor to the combinational memory-address mux of the multicycle MIPS core.
- Selects the memory address from PC, register-read address, ALU result, or an exception vector, then holds that address stable for the whole memory access.
- Keeps sticky pending-exception bits with fixed priority, and generates vector addresses from a parametrised base.
- Adds a timeout and error reporting. Sits between the control unit and the memory port.

Parameters:
- ADDR_W, 32, width of all address inputs and of mem_addr.
- NUM_VEC, 3, number of exception sources/vectors (1..16).
- VEC_BASE, 253, address of vector 0; vector i is at VEC_BASE+i, truncated to ADDR_W bits.
- TIMEOUT, 15, maximum WAIT cycles before abort (1..255).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- sel  in  2  source select: 00 PC, 01 exception vector, 10 RD address, 11 ALUOut.
- pc_src  in  ADDR_W  PC source address.
- rd_addr  in  ADDR_W  register-read address.
- alu_out  in  ADDR_W  ALU result address.
- req  in  1  start-access request; sampled only in IDLE.
- mem_ready  in  1  memory completion strobe.
- exc_req  in  NUM_VEC  exception set pulses/levels; bit 0 has highest priority.
- mem_addr  out  ADDR_W  registered address to memory.
- mem_valid  out  1  access in progress toward memory.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on access completion.
- exc_pending  out  NUM_VEC  sticky pending-exception bits.
- exc_cause  out  4  index of the vector used by the last vector access.
- err  out  1  sticky error flag; cleared by the next accepted req.
- err_code  out  2  00 none, 01 vector requested with nothing pending, 10 timeout.

Behaviour:
- Reset (reset=0, asynchronous, effective immediately, including mid-access):
  - mem_addr=0, mem_valid=0, busy=0, done=0, exc_pending=0, exc_cause=0, err=0, err_code=00.
  - State returns to IDLE and the timeout counter is cleared.
- States: IDLE, WAIT.
- IDLE, req=1:
  - Clear err/err_code.
  - sel=00/10/11: load mem_addr from pc_src/rd_addr/alu_out at the edge, set mem_valid=1, go to WAIT.
  - sel=01 with exc_pending!=0: pick the lowest set index i. Load mem_addr=VEC_BASE+i, set exc_cause=i, remember i, go to WAIT.
  - sel=01 with exc_pending==0: no access. Set err=1, err_code=01, stay in IDLE. mem_addr keeps its old value.
- IDLE, req=0: outputs hold. mem_valid=0.
- Latency: mem_addr and mem_valid are valid the cycle after req is accepted.
- WAIT:
  - mem_addr is frozen; sel and address-input changes are ignored. The counter increments every cycle.
  - mem_ready=1: next cycle done=1 for exactly one cycle, mem_valid=0, state IDLE, counter cleared.
  - If the access was a vector access, exc_pending[i] is cleared at that same edge.
  - mem_ready=1 in the first WAIT cycle is legal; the minimum access is 2 cycles from req to done.
  - Counter reaches TIMEOUT with no mem_ready: go to IDLE, mem_valid=0, done=0, err=1, err_code=10. Pending bits are not cleared.
  - mem_ready on the same cycle the counter reaches TIMEOUT: completion wins, no error.
- req while busy is ignored; it is not queued.
- exc_pending:
  - Each edge: exc_pending |= exc_req, in every state.
  - The clear of bit i on vector-access completion and a simultaneous exc_req[i]=1: the set wins, so the bit stays 1.
  - Bits raised during WAIT do not affect the current mem_addr.
- Address arithmetic: the VEC_BASE+i sum is truncated to ADDR_W. No wrap detection.
- mem_ready in IDLE is ignored.

Test Plan:
- Reset mid-WAIT: req, sel=10, rd_addr=0x40, then reset=0 two cycles later -> all outputs 0 immediately, state IDLE, no done.
- Plain access: sel=11, alu_out=0x1000, req for 1 cycle, mem_ready after 3 cycles -> mem_addr=0x1000 from cycle+1 through WAIT, done one cycle, mem_valid falls with done. alu_out changes during WAIT do not affect mem_addr.
- Vector priority: exc_req=3'b110 pulse, then req, sel=01 -> mem_addr=254, exc_cause=1. On completion exc_pending=3'b100. A second vector access -> mem_addr=255, then exc_pending=0.
- Set/clear collision: pending bit 0, vector access; exc_req[0]=1 on the mem_ready edge -> exc_pending[0] remains 1 after done.
- Empty vector: exc_pending=0, req, sel=01 -> err=1, err_code=01, busy stays 0, mem_valid 0. Next req sel=00, pc_src=0x4 -> err clears, mem_addr=0x4.
- Timeout: TIMEOUT=15, req sel=00, mem_ready never asserted -> after 15 WAIT cycles err_code=10, mem_valid=0, no done. Repeat with mem_ready on cycle 15 -> done=1, err=0.
